axi4_ddr_rd_arb: RTL and testbench

N:1 AXI4 read-channel arbiter placed in front of one DDR AXI4 slave port (the sh_cl_ddr read side).
- AR: round-robin arbitration among NUM_M requesters through a one-deep registered slice. The master index is encoded in the top ARID bits.
- R: beats are routed back to the owning master by RID. Per-master outstanding-burst limits keep one master from saturating the DDR read queue.
- Write channels are out of scope.

---
 rtl/axi4_ddr_arb_pkg.sv | 26 ++
 rtl/rr_arb_ptr.sv | 31 +++
 rtl/axi4_ddr_rd_arb.sv | 136 +++++++++++++
 tb/tb_axi4_ddr_rd_arb.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_ddr_arb_pkg.sv
// Shared AXI4 read-path types and constants for the DDR read arbiter.
package axi4_ddr_arb_pkg;

    localparam int AXI_ID_W   = 16;
    localparam int AXI_ADDR_W = 64;
    localparam int AXI_DATA_W = 512;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } ar_cmd_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } r_beat_t;

endpackage

// File: rtl/rr_arb_ptr.sv
// Round-robin priority picker: first request found after ptr (wrapping)
// wins. Purely combinational so it can sit in front of any registered slice.
module rr_arb_ptr #(
    parameter int NUM_M = 4,
    parameter int IDX_W = 2
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NUM_M-1:0] gnt,
    output logic [IDX_W-1:0] gidx,
    output logic             any
);

    // Scan ptr+1, ptr+2, ... modulo NUM_M; the last slot checked is ptr itself
    always_comb begin
        logic [IDX_W-1:0] idx;
        gnt  = '0;
        gidx = '0;
        any  = 1'b0;
        idx  = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_M);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gidx     = idx;
            end
        end
    end

endmodule

// File: rtl/axi4_ddr_rd_arb.sv
// N:1 AXI4 read arbiter in front of the DDR read port. AR goes through a
// one-deep registered slice with round-robin grant; R beats are steered back
// by the master index carried in the top ARID/RID bits.
module axi4_ddr_rd_arb
    import axi4_ddr_arb_pkg::*;
#(
    parameter int NUM_M   = 4,
    parameter int MAX_OUT = 16
) (
    input  logic                  clk_core,
    input  logic                  rst_n,
    input  ar_cmd_t [NUM_M-1:0]   m_ar,
    input  logic    [NUM_M-1:0]   m_arvalid,
    output logic    [NUM_M-1:0]   m_arready,
    output r_beat_t [NUM_M-1:0]   m_r,
    output logic    [NUM_M-1:0]   m_rvalid,
    input  logic    [NUM_M-1:0]   m_rready,
    output ar_cmd_t               s_ar,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  r_beat_t               s_r,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    output logic    [1:0]         err_sticky
);

    localparam int MIDX_W = $clog2(NUM_M);
    localparam int CNT_W  = $clog2(MAX_OUT + 1);
    localparam int ID_TOP = AXI_ID_W - 1;

    logic [CNT_W-1:0]  out_cnt_reg [NUM_M];
    logic [MIDX_W-1:0] rr_ptr_reg;
    ar_cmd_t           s_ar_reg;
    ar_cmd_t           s_ar_next;
    logic              s_arvalid_reg;
    logic [1:0]        err_reg;

    logic [NUM_M-1:0]  eligible;
    logic [NUM_M-1:0]  gnt;
    logic [MIDX_W-1:0] gidx;
    logic              any_req;
    logic              slice_free;
    logic              grant;
    logic              rsvd_id_hit;

    logic [MIDX_W-1:0] r_mi;
    logic [NUM_M-1:0]  r_hit;
    logic              r_known;
    logic              r_take;
    r_beat_t           r_clean;
    logic [NUM_M-1:0]  cnt_inc;
    logic [NUM_M-1:0]  cnt_dec;

    assign slice_free = !s_arvalid_reg || s_arready;
    assign grant      = slice_free && any_req;
    assign r_mi       = s_r.id[ID_TOP -: MIDX_W];

    rr_arb_ptr #(
        .NUM_M (NUM_M),
        .IDX_W (MIDX_W)
    ) u_rr (
        .req  (eligible),
        .ptr  (rr_ptr_reg),
        .gnt  (gnt),
        .gidx (gidx),
        .any  (any_req)
    );

    // Granted command with the master index stamped into the top ID bits
    always_comb begin
        s_ar_next = m_ar[gidx];
        s_ar_next.id[ID_TOP -: MIDX_W] = gidx;
        rsvd_id_hit = (m_ar[gidx].id[ID_TOP -: MIDX_W] != '0);
    end

    // Returned beat as seen by every master: routing bits hidden
    always_comb begin
        r_clean = s_r;
        r_clean.id[ID_TOP -: MIDX_W] = '0;
    end

    // A beat nobody is waiting for is swallowed so the DDR side never stalls on it
    assign r_known  = |r_hit;
    assign s_rready = !r_known || |(r_hit & m_rready);
    assign r_take   = s_rvalid && s_rready;

    for (genvar gi = 0; gi < NUM_M; gi++) begin : g_master
        assign eligible[gi]  = m_arvalid[gi] && (out_cnt_reg[gi] < CNT_W'(MAX_OUT));
        assign r_hit[gi]     = (r_mi == MIDX_W'(gi)) && (out_cnt_reg[gi] != '0);
        assign m_arready[gi] = rst_n && grant && gnt[gi];
        assign m_rvalid[gi]  = rst_n && s_rvalid && r_hit[gi];
        assign m_r[gi]       = r_clean;
        assign cnt_inc[gi]   = grant && gnt[gi];
        assign cnt_dec[gi]   = r_take && s_r.last && r_hit[gi];

        // Outstanding bursts: +1 per accepted AR, -1 per completed burst
        always_ff @(posedge clk_core or negedge rst_n) begin
            if (!rst_n) begin
                out_cnt_reg[gi] <= '0;
            end else if (cnt_inc[gi] && !cnt_dec[gi]) begin
                out_cnt_reg[gi] <= out_cnt_reg[gi] + CNT_W'(1);
            end else if (!cnt_inc[gi] && cnt_dec[gi]) begin
                out_cnt_reg[gi] <= out_cnt_reg[gi] - CNT_W'(1);
            end
        end
    end

    // AR slice, round-robin pointer and sticky error flags
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            s_ar_reg      <= '0;
            s_arvalid_reg <= 1'b0;
            rr_ptr_reg    <= MIDX_W'(NUM_M - 1);
            err_reg       <= 2'b00;
        end else begin
            if (grant) begin
                s_ar_reg      <= s_ar_next;
                s_arvalid_reg <= 1'b1;
                rr_ptr_reg    <= gidx;
            end else if (s_arready) begin
                s_arvalid_reg <= 1'b0;
            end
            if (s_rvalid && !r_known) begin
                err_reg[0] <= 1'b1;
            end
            if (grant && rsvd_id_hit) begin
                err_reg[1] <= 1'b1;
            end
        end
    end

    assign s_ar       = s_ar_reg;
    assign s_arvalid  = s_arvalid_reg;
    assign err_sticky = err_reg;

endmodule

// File: tb/tb_axi4_ddr_rd_arb.sv
// Bench for the DDR read arbiter: directed scenarios plus a randomized run,
// all checked against a transaction-level reference model.
module tb_axi4_ddr_rd_arb;
    import axi4_ddr_arb_pkg::*;

    localparam int NUM_M   = 4;
    localparam int MAX_OUT = 2;

    logic                 clk_core = 1'b0;
    logic                 rst_n    = 1'b0;
    ar_cmd_t [NUM_M-1:0]  m_ar;
    logic    [NUM_M-1:0]  m_arvalid;
    logic    [NUM_M-1:0]  m_arready;
    r_beat_t [NUM_M-1:0]  m_r;
    logic    [NUM_M-1:0]  m_rvalid;
    logic    [NUM_M-1:0]  m_rready;
    ar_cmd_t              s_ar;
    logic                 s_arvalid;
    logic                 s_arready;
    r_beat_t              s_r;
    logic                 s_rvalid;
    logic                 s_rready;
    logic    [1:0]        err_sticky;

    axi4_ddr_rd_arb #(.NUM_M(NUM_M), .MAX_OUT(MAX_OUT)) dut (
        .clk_core   (clk_core),
        .rst_n      (rst_n),
        .m_ar       (m_ar),
        .m_arvalid  (m_arvalid),
        .m_arready  (m_arready),
        .m_r        (m_r),
        .m_rvalid   (m_rvalid),
        .m_rready   (m_rready),
        .s_ar       (s_ar),
        .s_arvalid  (s_arvalid),
        .s_arready  (s_arready),
        .s_r        (s_r),
        .s_rvalid   (s_rvalid),
        .s_rready   (s_rready),
        .err_sticky (err_sticky)
    );

    always #5 clk_core = ~clk_core;

    int n_run  = 0;
    int n_fail = 0;

    // Reference model state: bursts in flight per master, last winner,
    // what the DDR side should currently see, sticky error flags
    int         mdl_cnt [NUM_M];
    int         mdl_last;
    bit         mdl_valid;
    ar_cmd_t    mdl_ar;
    logic [1:0] mdl_err;

    // Model predictions for the current cycle
    bit         exp_gnt_ok;
    int         exp_g;
    logic [3:0] exp_arready;
    logic [3:0] exp_rvalid;
    int         exp_mi;
    bit         exp_known;
    logic       exp_srready;
    r_beat_t    exp_mr;

    function automatic ar_cmd_t make_ar(input logic [15:0] id);
        ar_cmd_t a;
        a.id    = id;
        a.addr  = {$urandom, $urandom};
        a.len   = 8'($urandom_range(0, 255));
        a.size  = 3'd6;
        a.burst = BURST_INCR;
        return a;
    endfunction

    function automatic r_beat_t make_beat(input logic [15:0] id, input logic last);
        r_beat_t b;
        b.id = id;
        for (int w = 0; w < 16; w++) b.data[w*32 +: 32] = $urandom;
        b.resp = 2'($urandom_range(0, 3));
        b.last = last;
        return b;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < NUM_M; m++) mdl_cnt[m] = 0;
        mdl_last  = NUM_M - 1;
        mdl_valid = 0;
        mdl_ar    = '0;
        mdl_err   = 2'b00;
    endtask

    // Predict this cycle's outputs from the current inputs and model state
    task automatic model_eval();
        int idx;
        exp_gnt_ok = 0;
        exp_g      = 0;
        for (int k = 1; k <= NUM_M; k++) begin
            idx = (mdl_last + k) % NUM_M;
            if (!exp_gnt_ok && m_arvalid[idx] && mdl_cnt[idx] < MAX_OUT) begin
                exp_gnt_ok = 1;
                exp_g      = idx;
            end
        end
        if (mdl_valid && !s_arready) exp_gnt_ok = 0;
        exp_arready = exp_gnt_ok ? 4'(1 << exp_g) : 4'b0000;
        exp_mi      = int'(s_r.id[15:14]);
        exp_known   = mdl_cnt[exp_mi] > 0;
        exp_rvalid  = (s_rvalid && exp_known) ? 4'(1 << exp_mi) : 4'b0000;
        exp_srready = exp_known ? m_rready[exp_mi] : 1'b1;
        exp_mr      = s_r;
        exp_mr.id[15:14] = 2'b00;
    endtask

    // Apply this cycle's transactions to the model, then advance one clock
    task automatic model_commit();
        if (exp_gnt_ok) begin
            mdl_cnt[exp_g]++;
            mdl_ar = m_ar[exp_g];
            if (mdl_ar.id[15:14] != 2'b00) mdl_err[1] = 1'b1;
            mdl_ar.id[15:14] = 2'(exp_g);
            mdl_valid = 1;
            mdl_last  = exp_g;
            $display("[TB] AR  m%0d id=%h addr=%h len=%0d", exp_g, m_ar[exp_g].id, m_ar[exp_g].addr, m_ar[exp_g].len);
        end else if (s_arready) begin
            mdl_valid = 0;
        end
        if (s_rvalid && !exp_known) begin
            mdl_err[0] = 1'b1;
            $display("[TB] R   dropped rid=%h", s_r.id);
        end else if (s_rvalid && m_rready[exp_mi]) begin
            if (s_r.last) mdl_cnt[exp_mi]--;
            $display("[TB] R   m%0d rid=%h last=%0d", exp_mi, s_r.id, s_r.last);
        end
        @(posedge clk_core);
        #1;
    endtask

    task automatic idle_inputs();
        m_arvalid = '0;
        s_arready = 1'b1;
        s_rvalid  = 1'b0;
        m_rready  = '1;
        s_r       = '0;
        for (int m = 0; m < NUM_M; m++) m_ar[m] = make_ar(16'h0000);
    endtask

    // Return a final beat for every burst still in flight
    task automatic drain_all();
        m_arvalid = '0;
        s_arready = 1'b1;
        m_rready  = '1;
        for (int m = 0; m < NUM_M; m++) begin
            while (mdl_cnt[m] > 0) begin
                s_rvalid = 1'b1;
                s_r      = make_beat(16'(m << 14), 1'b1);
                @(negedge clk_core);
                model_eval();
                n_run++;
                if (m_rvalid !== 4'(1 << m)) begin
                    n_fail++;
                    $display("FAIL drain_rvalid m%0d: got %b want %b", m, m_rvalid, 4'(1 << m));
                end
                model_commit();
            end
        end
        s_rvalid = 1'b0;
        @(negedge clk_core);
        model_eval();
        model_commit();
    endtask

    task automatic test_reset();
        idle_inputs();
        m_arvalid = '1;
        s_rvalid  = 1'b1;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk_core);
        @(negedge clk_core);
        n_run++;
        if (s_arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %b want 0", s_arvalid); end
        n_run++;
        if (s_ar !== '0) begin n_fail++; $display("FAIL reset_s_ar: got %h want 0", s_ar); end
        n_run++;
        if (m_arready !== 4'b0000) begin n_fail++; $display("FAIL reset_arready: got %b want 0000", m_arready); end
        n_run++;
        if (m_rvalid !== 4'b0000) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0000", m_rvalid); end
        n_run++;
        if (err_sticky !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", err_sticky); end
        idle_inputs();
        model_reset();
        @(posedge clk_core);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_rr_order();
        int seq[5] = '{0, 1, 2, 3, 0};
        for (int m = 0; m < NUM_M; m++) m_ar[m] = make_ar(16'(m * 3));
        m_arvalid = '1;
        s_arready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_core);
            model_eval();
            n_run++;
            if (m_arready !== 4'(1 << seq[c])) begin
                n_fail++;
                $display("FAIL rr_grant c%0d: got %b want %b", c, m_arready, 4'(1 << seq[c]));
            end
            if (c > 0) begin
                n_run++;
                if (s_arvalid !== 1'b1 || s_ar.id[15:14] !== 2'(seq[c-1])) begin
                    n_fail++;
                    $display("FAIL rr_s_ar c%0d: got v=%b idx=%0d want v=1 idx=%0d", c, s_arvalid, s_ar.id[15:14], seq[c-1]);
                end
            end
            model_commit();
        end
        m_arvalid = '0;
        @(negedge clk_core);
        model_eval();
        n_run++;
        if (s_ar !== mdl_ar || s_ar.id !== 16'h0000) begin
            n_fail++;
            $display("FAIL rr_last_cmd: got %h want %h", s_ar, mdl_ar);
        end
        model_commit();
        drain_all();
    endtask

    task automatic test_backpressure();
        int      grants = 0;
        ar_cmd_t held   = '0;
        logic [3:0] want;
        m_ar[2]   = make_ar(16'h0123);
        m_arvalid = 4'b0100;
        s_arready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_core);
            model_eval();
            if (m_arready[2]) grants++;
            want = (c == 0) ? 4'b0100 : 4'b0000;
            n_run++;
            if (m_arready !== want) begin
                n_fail++;
                $display("FAIL stall_arready c%0d: got %b want %b", c, m_arready, want);
            end
            if (c == 1) begin
                held = s_ar;
                n_run++;
                if (s_ar !== mdl_ar) begin n_fail++; $display("FAIL stall_cmd: got %h want %h", s_ar, mdl_ar); end
            end
            if (c > 1) begin
                n_run++;
                if (s_arvalid !== 1'b1 || s_ar !== held) begin
                    n_fail++;
                    $display("FAIL stall_stable c%0d: got v=%b %h want v=1 %h", c, s_arvalid, s_ar, held);
                end
            end
            model_commit();
        end
        n_run++;
        if (grants != 1) begin n_fail++; $display("FAIL stall_grants: got %0d want 1", grants); end
        s_arready = 1'b1;
        @(negedge clk_core);
        model_eval();
        n_run++;
        if (m_arready !== exp_arready) begin
            n_fail++;
            $display("FAIL stall_release: got %b want %b", m_arready, exp_arready);
        end
        model_commit();
        drain_all();
    endtask

    task automatic test_max_out();
        logic [3:0] want;
        m_ar[1]   = make_ar(16'h0042);
        m_arvalid = 4'b0010;
        s_arready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_core);
            model_eval();
            want = (c < 2) ? 4'b0010 : 4'b0000;
            n_run++;
            if (m_arready !== want) begin
                n_fail++;
                $display("FAIL maxout_grant c%0d: got %b want %b", c, m_arready, want);
            end
            model_commit();
        end
        s_rvalid = 1'b1;
        s_r      = make_beat(16'h4000, 1'b1);
        m_rready = '1;
        @(negedge clk_core);
        model_eval();
        n_run++;
        if (m_arready !== 4'b0000 || m_rvalid !== 4'b0010 || s_rready !== 1'b1) begin
            n_fail++;
            $display("FAIL maxout_return: got ar=%b rv=%b rr=%b want 0000 0010 1", m_arready, m_rvalid, s_rready);
        end
        model_commit();
        s_rvalid = 1'b0;
        @(negedge clk_core);
        model_eval();
        n_run++;
        if (m_arready !== 4'b0010) begin
            n_fail++;
            $display("FAIL maxout_unblock: got %b want 0010", m_arready);
        end
        model_commit();
        drain_all();
    endtask

    task automatic test_unexpected();
        @(negedge clk_core);
        n_run++;
        if (err_sticky !== 2'b00) begin n_fail++; $display("FAIL unexp_pre_err: got %b want 00", err_sticky); end
        s_rvalid = 1'b1;
        s_r      = make_beat(16'hC000, 1'b1);
        m_rready = '0;
        @(negedge clk_core);
        model_eval();
        n_run++;
        if (s_rready !== 1'b1 || m_rvalid !== 4'b0000) begin
            n_fail++;
            $display("FAIL unexp_drop: got rr=%b rv=%b want 1 0000", s_rready, m_rvalid);
        end
        model_commit();
        s_rvalid = 1'b0;
        m_rready = '1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_core);
            model_eval();
            n_run++;
            if (err_sticky[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL unexp_err_hold c%0d: got %b want 1", c, err_sticky[0]);
            end
            model_commit();
        end
    endtask

    task automatic test_r_backpressure();
        m_ar[2]   = make_ar(16'h0000);
        m_arvalid = 4'b0100;
        s_arready = 1'b1;
        @(negedge clk_core);
        model_eval();
        model_commit();
        m_arvalid = '0;
        s_rvalid  = 1'b1;
        s_r       = make_beat(16'h8005, 1'b1);
        m_rready  = 4'b1011;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_core);
            model_eval();
            n_run++;
            if (m_rvalid !== 4'b0100 || s_rready !== 1'b0 || m_r[2].id !== 16'h0005) begin
                n_fail++;
                $display("FAIL rbp_hold c%0d: got rv=%b rr=%b id=%h want 0100 0 0005", c, m_rvalid, s_rready, m_r[2].id);
            end
            model_commit();
        end
        m_rready = '1;
        @(negedge clk_core);
        model_eval();
        n_run++;
        if (m_rvalid !== 4'b0100 || s_rready !== 1'b1) begin
            n_fail++;
            $display("FAIL rbp_accept: got rv=%b rr=%b want 0100 1", m_rvalid, s_rready);
        end
        model_commit();
        // Same RID again: the burst is complete, so it must now be dropped
        @(negedge clk_core);
        model_eval();
        n_run++;
        if (m_rvalid !== 4'b0000 || s_rready !== 1'b1) begin
            n_fail++;
            $display("FAIL rbp_decrement: got rv=%b rr=%b want 0000 1", m_rvalid, s_rready);
        end
        model_commit();
        s_rvalid = 1'b0;
    endtask

    task automatic test_reserved_id();
        m_ar[0]   = make_ar(16'h4001);
        m_arvalid = 4'b0001;
        s_arready = 1'b0;
        @(negedge clk_core);
        model_eval();
        n_run++;
        if (m_arready !== 4'b0001) begin n_fail++; $display("FAIL rsvd_grant: got %b want 0001", m_arready); end
        model_commit();
        @(negedge clk_core);
        n_run++;
        if (s_ar.id !== 16'h0001 || err_sticky[1] !== 1'b1 || s_arvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL rsvd_id: got id=%h err=%b v=%b want 0001 1x 1", s_ar.id, err_sticky, s_arvalid);
        end
        // Asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        n_run++;
        if (s_arvalid !== 1'b0 || s_ar !== '0 || err_sticky !== 2'b00 || m_arready !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b ar=%h err=%b rdy=%b want 0 0 00 0000", s_arvalid, s_ar, err_sticky, m_arready);
        end
        model_reset();
        idle_inputs();
        @(posedge clk_core);
        #1;
        rst_n = 1'b1;
        // Master 0 had a burst in flight before reset; its beat is now unexpected
        s_rvalid = 1'b1;
        s_r      = make_beat(16'h0000, 1'b1);
        m_rready = '0;
        @(negedge clk_core);
        model_eval();
        n_run++;
        if (s_rready !== 1'b1 || m_rvalid !== 4'b0000) begin
            n_fail++;
            $display("FAIL post_reset_cnt: got rr=%b rv=%b want 1 0000", s_rready, m_rvalid);
        end
        model_commit();
        s_rvalid = 1'b0;
        m_rready = '1;
    endtask

    task automatic test_random();
        int mi;
        logic [15:0] id;
        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < NUM_M; m++) begin
                if ($urandom_range(0, 3) == 0) begin
                    id = 16'($urandom_range(0, 16'h3FFF));
                    if ($urandom_range(0, 15) == 0) id[15:14] = 2'($urandom_range(1, 3));
                    m_ar[m] = make_ar(id);
                end
            end
            m_arvalid = 4'($urandom_range(0, 15));
            s_arready = ($urandom_range(0, 3) != 0);
            m_rready  = 4'($urandom_range(0, 15));
            s_rvalid  = ($urandom_range(0, 1) == 1);
            mi = $urandom_range(0, NUM_M - 1);
            if ($urandom_range(0, 7) != 0 && mdl_cnt[mi] == 0) begin
                for (int m = 0; m < NUM_M; m++) if (mdl_cnt[m] > 0) mi = m;
            end
            s_r = make_beat({2'(mi), 14'($urandom_range(0, 16'h3FFF))}, $urandom_range(0, 2) == 0);
            @(negedge clk_core);
            model_eval();
            n_run++;
            if (m_arready !== exp_arready) begin n_fail++; $display("FAIL rnd_arready c%0d: got %b want %b", c, m_arready, exp_arready); end
            n_run++;
            if (s_arvalid !== mdl_valid || s_ar !== mdl_ar) begin
                n_fail++;
                $display("FAIL rnd_s_ar c%0d: got v=%b %h want v=%b %h", c, s_arvalid, s_ar, mdl_valid, mdl_ar);
            end
            n_run++;
            if (m_rvalid !== exp_rvalid || s_rready !== exp_srready) begin
                n_fail++;
                $display("FAIL rnd_r c%0d: got rv=%b rr=%b want %b %b", c, m_rvalid, s_rready, exp_rvalid, exp_srready);
            end
            for (int m = 0; m < NUM_M; m++) begin
                n_run++;
                if (m_r[m] !== exp_mr) begin
                    n_fail++;
                    $display("FAIL rnd_m_r c%0d m%0d: got id=%h last=%b want id=%h last=%b", c, m, m_r[m].id, m_r[m].last, exp_mr.id, exp_mr.last);
                end
            end
            n_run++;
            if (err_sticky !== mdl_err) begin n_fail++; $display("FAIL rnd_err c%0d: got %b want %b", c, err_sticky, mdl_err); end
            model_commit();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_rr_order();
        test_backpressure();
        test_max_out();
        test_unexpected();
        test_r_backpressure();
        test_reserved_id();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
